tftlcd_pong_axil_regs: RTL

// - AXI4-Lite slave (responder) holding the pong peripheral's 4 x 32-bit control registers.
// - Answers the single-beat AXI4LITE_WRITE_BURST / AXI4LITE_READ_BURST traffic issued by the PS or VIP master.
// - Drives the register contents and per-register write pulses to the TFT-LCD pong datapath.

---
 rtl/tftlcd_pong_axil_pkg.sv | 23 ++
 rtl/tftlcd_pong_axil_regs.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/tftlcd_pong_axil_pkg.sv
// rtl/tftlcd_pong_axil_pkg.sv - shared constants and types for the pong AXI4-Lite register block
package tftlcd_pong_axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         NUM_REGS    = 4;
  localparam int         ADDR_LSB    = 2;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } wr_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } rd_state_t;

  typedef logic [1:0] reg_idx_t;

endpackage

// File: rtl/tftlcd_pong_axil_regs.sv
// rtl/tftlcd_pong_axil_regs.sv - AXI4-Lite responder holding the four pong control registers
module tftlcd_pong_axil_regs
  import tftlcd_pong_axil_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]               wr_pulse_o
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] regs_q;

  wr_state_t                     wr_state_q, wr_state_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;
  logic [1:0]                    bresp_q;
  logic [NUM_REGS-1:0]           wr_pulse_q;

  rd_state_t                     rd_state_q, rd_state_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                    rresp_q;

  logic                          aw_hs, w_hs, ar_hs;
  logic                          commit;
  logic [C_S_AXI_ADDR_WIDTH-1:0] cmt_addr;
  logic [C_S_AXI_DATA_WIDTH-1:0] cmt_data;
  logic [STRB_W-1:0]             cmt_strb;
  logic                          cmt_oor;
  reg_idx_t                      cmt_idx;
  logic                          ar_oor;
  reg_idx_t                      ar_idx;

  // Readies and valids come straight from the registered FSM states
  assign S_AXI_AWREADY = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_W);
  assign S_AXI_WREADY  = (wr_state_q == W_IDLE) || (wr_state_q == W_HAVE_AW);
  assign S_AXI_BVALID  = (wr_state_q == W_RESP);
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = (rd_state_q == R_IDLE);
  assign S_AXI_RVALID  = (rd_state_q == R_RESP);
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign regs_o        = regs_q;
  assign wr_pulse_o    = wr_pulse_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

  // Any address bit above the 16-byte register window marks the access out of range
  assign cmt_oor = (cmt_addr >> 4) != '0;
  assign cmt_idx = cmt_addr[ADDR_LSB +: 2];
  assign ar_oor  = (S_AXI_ARADDR >> 4) != '0;
  assign ar_idx  = S_AXI_ARADDR[ADDR_LSB +: 2];

  // Write FSM next state; picks live or latched address/data for the completing handshake
  always_comb begin
    wr_state_d = wr_state_q;
    commit     = 1'b0;
    cmt_addr   = S_AXI_AWADDR;
    cmt_data   = S_AXI_WDATA;
    cmt_strb   = S_AXI_WSTRB;
    case (wr_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end else if (aw_hs) begin
          wr_state_d = W_HAVE_AW;
        end else if (w_hs) begin
          wr_state_d = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        cmt_addr = aw_addr_q;
        if (w_hs) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_HAVE_W: begin
        cmt_data = wdata_q;
        cmt_strb = wstrb_q;
        if (aw_hs) begin
          commit     = 1'b1;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (S_AXI_BREADY) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write state, half-transaction latches, register commit, response and pulse
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      wr_state_q <= W_IDLE;
      aw_addr_q  <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
      regs_q     <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_pulse_q <= '0;
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR;
      if (w_hs) begin
        wdata_q <= S_AXI_WDATA;
        wstrb_q <= S_AXI_WSTRB;
      end
      if (commit) begin
        bresp_q <= cmt_oor ? RESP_SLVERR : RESP_OKAY;
        if (!cmt_oor) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (cmt_strb[b]) regs_q[cmt_idx][8*b +: 8] <= cmt_data[8*b +: 8];
          end
          if (|cmt_strb) wr_pulse_q[cmt_idx] <= 1'b1;
        end
      end
    end
  end

  // Read FSM next state
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_IDLE:  if (ar_hs) rd_state_d = R_RESP;
      R_RESP:  if (S_AXI_RREADY) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read state and captured response; sampling regs_q here yields the pre-commit value
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      rd_state_q <= R_IDLE;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_d;
      if (ar_hs) begin
        rdata_q <= ar_oor ? '0 : regs_q[ar_idx];
        rresp_q <= ar_oor ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule
